// File: rtl/c_batch_stats.sv
// c_batch_stats: collects N 3-bit values over a dav_/rfd handshake and offers sum/max/err downstream over a second handshake
// clock/reset_      : clock, async active-high reset
// c, dav_, rfd      : upstream value, data-valid (active-low), ready-for-data
// sum, maxv, err    : batch result, valid while dav_out_ is low
// dav_out_, rfd_out : downstream result-valid (active-low), ready-for-data
module c_batch_stats #(
  parameter int N = 8
) (
  input  logic       clock,
  input  logic       reset_,
  input  logic [2:0] c,
  input  logic       dav_,
  output logic       rfd,
  output logic [6:0] sum,
  output logic [2:0] maxv,
  output logic       err,
  output logic       dav_out_,
  input  logic       rfd_out
);
  typedef enum logic [1:0] {W0, W1, O0, O1} state_t;
  state_t     star_q, star_d;
  logic [6:0] sum_q, sum_d;
  logic [2:0] max_q, max_d;
  logic       err_q, err_d;
  logic [4:0] cnt_q, cnt_d;
  logic       rfd_q, rfd_d;
  logic       dav_out_q, dav_out_d;
  always_ff @(posedge clock or posedge reset_)
    if (reset_) begin
      star_q    <= W0;
      sum_q     <= '0;
      max_q     <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      rfd_q     <= 1'b1;
      dav_out_q <= 1'b1;
    end else begin
      star_q    <= star_d;
      sum_q     <= sum_d;
      max_q     <= max_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      rfd_q     <= rfd_d;
      dav_out_q <= dav_out_d;
    end
  always_comb begin
    star_d    = star_q;
    sum_d     = sum_q;
    max_d     = max_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    rfd_d     = rfd_q;
    dav_out_d = dav_out_q;
    case (star_q)
      W0: if (!dav_) begin
        sum_d  = sum_q + {4'b0, c};
        max_d  = c > max_q ? c : max_q;
        err_d  = err_q | (c > 3'd4);
        cnt_d  = cnt_q + 5'd1;
        rfd_d  = 1'b0;
        star_d = W1;
      end
      W1: if (dav_) begin
        rfd_d     = 1'b1;
        dav_out_d = cnt_q == 5'(N) ? 1'b0 : 1'b1;
        star_d    = cnt_q == 5'(N) ? O0 : W0;
      end
      O0: if (!rfd_out) begin
        dav_out_d = 1'b1;
        star_d    = O1;
      end
      default: if (rfd_out) begin
        sum_d  = '0;
        max_d  = '0;
        err_d  = 1'b0;
        cnt_d  = '0;
        star_d = W0;
      end
    endcase
  end
  assign rfd      = rfd_q;
  assign dav_out_ = dav_out_q;
  assign sum      = sum_q;
  assign maxv     = max_q;
  assign err      = err_q;
endmodule

// File: tb/tb_c_batch_stats.sv
// tb_c_batch_stats: checks c_batch_stats (N=8 and N=1 instances) with directed tables, corner sequences and a random model
module tb_c_batch_stats;
  logic            clock = 1'b0;
  logic            reset_ = 1'b0;
  logic [1:0][2:0] c_w = '0;
  logic [1:0]      dav_w = 2'b11;
  logic [1:0]      rfd_w;
  logic [1:0][6:0] sum_w;
  logic [1:0][2:0] max_w;
  logic [1:0]      err_w;
  logic [1:0]      dav_out_w;
  logic [1:0]      rfd_out_w = 2'b11;
  int tests = 0;
  int fails = 0;
  always #5 clock = ~clock;
  c_batch_stats #(.N(8)) dut8 (
    .clock(clock), .reset_(reset_), .c(c_w[0]), .dav_(dav_w[0]), .rfd(rfd_w[0]),
    .sum(sum_w[0]), .maxv(max_w[0]), .err(err_w[0]), .dav_out_(dav_out_w[0]), .rfd_out(rfd_out_w[0])
  );
  c_batch_stats #(.N(1)) dut1 (
    .clock(clock), .reset_(reset_), .c(c_w[1]), .dav_(dav_w[1]), .rfd(rfd_w[1]),
    .sum(sum_w[1]), .maxv(max_w[1]), .err(err_w[1]), .dav_out_(dav_out_w[1]), .rfd_out(rfd_out_w[1])
  );
  typedef struct {
    logic [23:0] vals;
    int          s;
    int          m;
    int          e;
  } vec_t;
  vec_t tbl[5];
  function automatic logic [23:0] pk(int a, int b, int c, int d, int e, int f, int g, int h);
    return {3'(h), 3'(g), 3'(f), 3'(e), 3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction
  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask
  function automatic logic rd(int i, int w);
    return w == 0 ? rfd_w[i] : dav_out_w[i];
  endfunction
  task automatic wait_for(string nm, int i, int w, logic v);
    int k = 0;
    while (rd(i, w) !== v && k < 300) begin
      @(negedge clock);
      k++;
    end
    if (rd(i, w) !== v) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: signal is %b, expected %b", nm, rd(i, w), v);
    end
  endtask
  task automatic send(int i, int v);
    repeat ($urandom_range(0, 2)) @(negedge clock);
    wait_for("send_ready", i, 0, 1'b1);
    c_w[i] = 3'(v);
    dav_w[i] = 1'b0;
    wait_for("send_ack", i, 0, 1'b0);
    repeat ($urandom_range(0, 2)) @(negedge clock);
    dav_w[i] = 1'b1;
    wait_for("send_release", i, 0, 1'b1);
  endtask
  task automatic recv(string nm, int i, int es, int em, int ee);
    wait_for({nm, "_valid"}, i, 1, 1'b0);
    chk({nm, "_sum"}, 32'(sum_w[i]), es);
    chk({nm, "_max"}, 32'(max_w[i]), em);
    chk({nm, "_err"}, 32'(err_w[i]), ee);
    repeat ($urandom_range(0, 3)) @(negedge clock);
    rfd_out_w[i] = 1'b0;
    wait_for({nm, "_drop"}, i, 1, 1'b1);
    repeat ($urandom_range(0, 3)) @(negedge clock);
    chk({nm, "_sum_held"}, 32'(sum_w[i]), es);
    rfd_out_w[i] = 1'b1;
    @(negedge clock);
    chk({nm, "_cleared"}, 32'({sum_w[i], max_w[i], err_w[i]}), 0);
  endtask
  task automatic chk_reset(string nm, int i);
    chk(nm, 32'({rfd_w[i], dav_out_w[i], sum_w[i], max_w[i], err_w[i]}), 32'h1800);
  endtask
  initial begin
    int q[$];
    int es, em, ee, n;
    tbl[0] = '{pk(0, 1, 2, 3, 4, 4, 2, 1), 17, 4, 0};
    tbl[1] = '{pk(4, 4, 4, 4, 4, 4, 4, 7), 35, 7, 1};
    tbl[2] = '{pk(0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0};
    tbl[3] = '{pk(7, 7, 7, 7, 7, 7, 7, 7), 56, 7, 1};
    tbl[4] = '{pk(5, 0, 0, 0, 0, 0, 0, 0), 5, 5, 1};
    #2 reset_ = 1'b1;
    #1 chk_reset("reset8", 0);
    chk_reset("reset1", 1);
    repeat (2) @(negedge clock);
    reset_ = 1'b0;
    @(negedge clock);
    foreach (tbl[r]) begin
      for (int j = 0; j < 8; j++) send(0, int'(tbl[r].vals[3*j +: 3]));
      recv($sformatf("table%0d", r), 0, tbl[r].s, tbl[r].m, tbl[r].e);
    end
    for (int j = 0; j < 8; j++) send(0, 2);
    wait_for("bp_valid", 0, 1, 1'b0);
    c_w[0] = 3'd3;
    dav_w[0] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      chk("bp_rfd", 32'(rfd_w[0]), 1);
      chk("bp_sum", 32'(sum_w[0]), 16);
    end
    rfd_out_w[0] = 1'b0;
    wait_for("bp_drop", 0, 1, 1'b1);
    rfd_out_w[0] = 1'b1;
    wait_for("bp_accept", 0, 0, 1'b0);
    dav_w[0] = 1'b1;
    wait_for("bp_release", 0, 0, 1'b1);
    for (int j = 0; j < 7; j++) send(0, 0);
    recv("bp_next", 0, 3, 3, 0);
    send(1, 3);
    recv("n1_first", 1, 3, 3, 0);
    send(1, 0);
    recv("n1_second", 1, 0, 0, 0);
    for (int j = 0; j < 5; j++) send(0, 4);
    #2 reset_ = 1'b1;
    #1 chk_reset("midreset8", 0);
    @(negedge clock);
    reset_ = 1'b0;
    @(negedge clock);
    for (int j = 0; j < 8; j++) send(0, 1);
    recv("after_reset", 0, 8, 1, 0);
    repeat (30) @(negedge clock);
    chk("no_extra_result", 32'(dav_out_w[0]), 1);
    for (int b = 0; b < 60; b++) begin
      int i = b % 2;
      n = i == 0 ? 8 : 1;
      q.delete();
      for (int j = 0; j < n; j++) begin
        int v = $urandom_range(0, 9) == 0 ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
        q.push_back(v);
        send(i, v);
      end
      es = 0;
      em = 0;
      ee = 0;
      foreach (q[k]) begin
        es += q[k];
        if (q[k] > em) em = q[k];
        if (q[k] > 4) ee = 1;
      end
      recv($sformatf("rand%0d", b), i, es, em, ee);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
